// File: rtl/attn_pkg.sv
// Shared types and widths for the attention-engine operand feeder.
package attn_pkg;

  localparam int unsigned OpW          = 8;   // Q0.7 operand byte
  localparam int unsigned ResW         = 9;   // UQ3.6 e^x result
  localparam int unsigned SumW         = 11;  // running sum of one run's results
  localparam int unsigned AddrW        = 5;
  localparam int unsigned NFeatDefault = 4;
  localparam int unsigned NKeysDefault = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSendA,
    StSendB,
    StDrain
  } feeder_state_e;

endpackage

// File: rtl/attn_result_acc.sv
// Result collector: accepts engine results, stores them in arrival order and keeps their sum.
module attn_result_acc
  import attn_pkg::*;
#(
  parameter int unsigned NKeys = NKeysDefault,
  localparam int unsigned CntW = $clog2(NKeys + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            busy_i,
  input  logic [ResW-1:0] rx_data_i,
  input  logic            rx_vld_i,
  output logic            rx_rdy_o,
  input  logic [1:0]      res_sel_i,
  output logic [ResW-1:0] res_out_o,
  output logic [SumW-1:0] sum_o,
  output logic [CntW-1:0] count_o
);

  logic [ResW-1:0] res_q [NKeys];
  logic [ResW-1:0] res_d [NKeys];
  logic [CntW-1:0] count_q, count_d;
  logic [SumW-1:0] sum_q, sum_d;
  logic            accept;

  // Results are taken while a run is active and there is still room for one
  assign rx_rdy_o = busy_i && (count_q < CntW'(NKeys));
  assign accept   = rx_vld_i && rx_rdy_o;
  assign sum_o    = sum_q;
  assign count_o  = count_q;

  // Next-state: clear on run start, otherwise store/count/accumulate on each accepted result
  always_comb begin
    res_d   = res_q;
    count_d = count_q;
    sum_d   = sum_q;
    if (clear_i) begin
      count_d = '0;
      sum_d   = '0;
    end else if (accept) begin
      for (int unsigned r = 0; r < NKeys; r++) begin
        if (32'(count_q) == r) res_d[r] = rx_data_i;
      end
      count_d = count_q + 1'b1;
      sum_d   = sum_q + SumW'(rx_data_i);
    end
  end

  // Combinational read port of the result store
  always_comb begin
    res_out_o = '0;
    for (int unsigned r = 0; r < NKeys; r++) begin
      if (32'(res_sel_i) == r) res_out_o = res_q[r];
    end
  end

  // Result store, count and sum registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_q   <= '{default: '0};
      count_q <= '0;
      sum_q   <= '0;
    end else begin
      res_q   <= res_d;
      count_q <= count_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: rtl/attn_feeder.sv
// Streams q/k operand byte pairs to the attention engine and collects its e^x results.
module attn_feeder
  import attn_pkg::*;
#(
  parameter int unsigned N_FEAT = NFeatDefault,
  parameter int unsigned N_KEYS = NKeysDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_we,
  input  logic [AddrW-1:0] ld_addr,
  input  logic [OpW-1:0]   ld_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [OpW-1:0]   tx_data,
  output logic             tx_vld,
  input  logic             tx_rdy,
  input  logic [ResW-1:0]  rx_data,
  input  logic             rx_vld,
  output logic             rx_rdy,
  input  logic [1:0]       res_sel,
  output logic [ResW-1:0]  res_out,
  output logic [SumW-1:0]  sum_out
);

  localparam int unsigned IW   = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int unsigned JW   = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
  localparam int unsigned CntW = $clog2(N_KEYS + 1);

  feeder_state_e   state_q, state_d;
  logic [IW-1:0]   i_q, i_d;
  logic [JW-1:0]   j_q, j_d;
  logic [OpW-1:0]  q_q [N_FEAT];
  logic [OpW-1:0]  q_d [N_FEAT];
  logic [OpW-1:0]  k_q [N_KEYS][N_FEAT];
  logic [OpW-1:0]  k_d [N_KEYS][N_FEAT];
  logic [CntW-1:0] count;
  logic            clear;
  logic            last_i, last_j;

  assign busy   = (state_q != StIdle);
  assign last_i = (i_q == IW'(N_FEAT - 1));
  assign last_j = (j_q == JW'(N_KEYS - 1));

  // Operand writes are only honoured while idle, so bytes stay stable during a run
  always_comb begin
    q_d = q_q;
    k_d = k_q;
    if (ld_we && (state_q == StIdle)) begin
      for (int unsigned f = 0; f < N_FEAT; f++) begin
        if (32'(ld_addr) == f) q_d[f] = ld_data;
        for (int unsigned r = 0; r < N_KEYS; r++) begin
          if (32'(ld_addr) == N_FEAT + N_FEAT * r + f) k_d[r][f] = ld_data;
        end
      end
    end
  end

  // Sequencer: q[i], k[j][i] per pair; indices move only on an accepted byte
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    tx_vld  = 1'b0;
    tx_data = '0;
    clear   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSendA;
          i_d     = '0;
          j_d     = '0;
          clear   = 1'b1;
        end
      end
      StSendA: begin
        tx_vld  = 1'b1;
        tx_data = q_q[i_q];
        if (tx_rdy) state_d = StSendB;
      end
      StSendB: begin
        tx_vld  = 1'b1;
        tx_data = k_q[j_q][i_q];
        if (tx_rdy) begin
          state_d = StSendA;
          if (last_i) begin
            i_d = '0;
            if (last_j) begin
              j_d     = '0;
              state_d = StDrain;
            end else begin
              j_d = j_q + 1'b1;
            end
          end else begin
            i_d = i_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (count == CntW'(N_KEYS)) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer and operand registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      q_q     <= '{default: '0};
      k_q     <= '{default: '{default: '0}};
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      q_q     <= q_d;
      k_q     <= k_d;
    end
  end

  attn_result_acc #(
    .NKeys(N_KEYS)
  ) u_acc (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clear_i  (clear),
    .busy_i   (busy),
    .rx_data_i(rx_data),
    .rx_vld_i (rx_vld),
    .rx_rdy_o (rx_rdy),
    .res_sel_i(res_sel),
    .res_out_o(res_out),
    .sum_o    (sum_out),
    .count_o  (count)
  );

endmodule

// File: tb/tb_attn_feeder.sv
// Directed bench for attn_feeder: byte order, back-pressure, result collection and reset.
module tb_attn_feeder;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic        ld_we   = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic        start   = 1'b0;
  logic        busy, done;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_rdy  = 1'b0;
  logic [8:0]  rx_data = '0;
  logic        rx_vld  = 1'b0;
  logic        rx_rdy;
  logic [1:0]  res_sel = '0;
  logic [8:0]  res_out;
  logic [10:0] sum_out;

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0] mq [4];
  logic [7:0] mk [4][4];
  logic [8:0] rv [4];

  always #5 clk = ~clk;

  attn_feeder #(
    .N_FEAT(4),
    .N_KEYS(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld_we  (ld_we),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .tx_data(tx_data),
    .tx_vld (tx_vld),
    .tx_rdy (tx_rdy),
    .rx_data(rx_data),
    .rx_vld (rx_vld),
    .rx_rdy (rx_rdy),
    .res_sel(res_sel),
    .res_out(res_out),
    .sum_out(sum_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Byte b of a run: even -> q[i], odd -> k[j][i], pair p = b/2 walks i fastest
  function automatic logic [7:0] exp_byte(input int b);
    int p = b / 2;
    int j = p / 4;
    int i = p % 4;
    return (b % 2 == 0) ? mq[i] : mk[j][i];
  endfunction

  task automatic load_ops();
    for (int a = 0; a < 22; a++) begin
      @(negedge clk);
      ld_we   = 1'b1;
      ld_addr = 5'(a);
      if (a < 4)       ld_data = mq[a];
      else if (a < 20) ld_data = mk[(a - 4) / 4][(a - 4) % 4];
      else             ld_data = 8'hEE;  // out of range, must be dropped
    end
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  // One full run; result r is offered once 8*r+7 bytes have been accepted
  task automatic run_case(input int rdy_mode, input bit disturb);
    int         sent   = 0;
    int         ri     = 0;
    int         dones  = 0;
    bit         waited = 1'b0;
    bit         hold   = 1'b0;
    bit         fin    = 1'b0;
    logic [7:0] held   = '0;
    logic [10:0] esum  = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (done) dones++;
      if (!busy) begin
        fin = 1'b1;
      end else begin
        check_eq("rx_rdy", rx_rdy, ri < 4);
        if (ri < 4 && sent >= 8 * ri + 7) begin
          rx_vld  = 1'b1;
          rx_data = rv[ri];
          if (rx_rdy) ri++;
        end else begin
          rx_vld = 1'b0;
        end
        if (hold) check_eq("tx_hold", {tx_vld, tx_data}, {1'b1, held});
        tx_rdy = !(rdy_mode == 1 && sent % 2 == 1 && !waited);
        hold   = 1'b0;
        if (tx_vld) begin
          if (tx_rdy) begin
            if (sent < 32) check_eq("tx_byte", tx_data, exp_byte(sent));
            else           check_eq("tx_extra", sent, 31);
            sent++;
            waited = 1'b0;
          end else begin
            waited = 1'b1;
            hold   = 1'b1;
            held   = tx_data;
          end
        end
        if (disturb && cyc == 5) begin
          start   = 1'b1;
          ld_we   = 1'b1;
          ld_addr = 5'd0;
          ld_data = 8'hAA;
        end else begin
          start = 1'b0;
          ld_we = 1'b0;
        end
        @(negedge clk);
      end
    end
    tx_rdy = 1'b0;
    rx_vld = 1'b0;
    start  = 1'b0;
    ld_we  = 1'b0;
    check_eq("run_finished", fin, 1);
    check_eq("n_bytes", sent, 32);
    check_eq("n_done", dones, 1);
    check_eq("n_results", ri, 4);
    for (int r = 0; r < 4; r++) esum = esum + 11'(rv[r]);
    check_eq("sum_out", sum_out, esum);
    for (int r = 0; r < 4; r++) begin
      res_sel = 2'(r);
      #1;
      check_eq("res_out", res_out, rv[r]);
    end
  endtask

  initial begin
    int sent;
    int dones;

    // Reset state
    #2 rst_n = 1'b0;
    #8;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_tx_vld", tx_vld, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_rx_rdy", rx_rdy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_sum", sum_out, 0);
    check_eq("rst_res", res_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Results offered while idle are refused
    @(negedge clk);
    rx_vld  = 1'b1;
    rx_data = 9'h155;
    repeat (3) begin
      @(negedge clk);
      check_eq("idle_rx_rdy", rx_rdy, 0);
    end
    rx_vld = 1'b0;
    check_eq("idle_sum", sum_out, 0);
    check_eq("idle_res", res_out, 0);
    check_eq("idle_busy", busy, 0);

    // Uniform operands, engine always ready
    for (int i = 0; i < 4; i++) begin
      mq[i] = 8'h40;
      for (int j = 0; j < 4; j++) mk[j][i] = 8'h20;
    end
    rv[0] = 9'h040; rv[1] = 9'h080; rv[2] = 9'h100; rv[3] = 9'h1FF;
    load_ops();
    run_case(0, 1'b0);
    check_eq("sum_3bf", sum_out, 11'h3BF);

    // Distinct operands, ready low once per pair, start/ld_we poked mid-run
    for (int i = 0; i < 4; i++) begin
      mq[i] = 8'(1 + i);
      for (int j = 0; j < 4; j++) mk[j][i] = 8'(16 * (j + 1) + i);
    end
    rv[0] = 9'h001; rv[1] = 9'h0A0; rv[2] = 9'h1FF; rv[3] = 9'h123;
    load_ops();
    run_case(1, 1'b1);
    // q0 must not have picked up the write issued while busy
    run_case(0, 1'b0);
    check_eq("sum_3c3", sum_out, 11'h3C3);

    // Reset after five bytes
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sent  = 0;
    dones = 0;
    for (int cyc = 0; cyc < 100 && sent < 5; cyc++) begin
      tx_rdy = 1'b1;
      if (tx_vld) sent++;
      if (done) dones++;
      @(negedge clk);
    end
    tx_rdy = 1'b0;
    check_eq("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tx_vld", tx_vld, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    check_eq("mid_rst_rx_rdy", rx_rdy, 0);
    check_eq("mid_rst_dones", dones, 0);
    @(negedge clk);
    check_eq("mid_rst_sum", sum_out, 0);
    res_sel = 2'd2;
    #1;
    check_eq("mid_rst_res", res_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Operands were cleared by reset: the next run streams zeros
    for (int i = 0; i < 4; i++) begin
      mq[i] = 8'h00;
      for (int j = 0; j < 4; j++) mk[j][i] = 8'h00;
    end
    rv[0] = 9'h010; rv[1] = 9'h020; rv[2] = 9'h030; rv[3] = 9'h040;
    run_case(0, 1'b0);

    // Fresh operands after reset: stream restarts at q0
    for (int i = 0; i < 4; i++) begin
      mq[i] = 8'(8'h71 + 8'(i));
      for (int j = 0; j < 4; j++) mk[j][i] = 8'(8'h81 + 8'(4 * j + i));
    end
    rv[0] = 9'h0FF; rv[1] = 9'h001; rv[2] = 9'h100; rv[3] = 9'h002;
    load_ops();
    run_case(0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/attn_feeder.md
ATTN_FEEDER -- requirements
Module: attn_feeder

Interface
REQ-001 SHALL have parameter N_FEAT, default 4, meaning the number of features per dot product (Q0.7 byte pairs per result).
REQ-002 SHALL have parameter N_KEYS, default 4, meaning the number of key rows streamed and results collected per run.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port ld_we, input, 1 bit: operand write strobe.
REQ-006 SHALL have port ld_addr, input, 5 bits: addresses 0..N_FEAT-1 select q[i]; address N_FEAT+N_FEAT*j+i selects k[j][i].
REQ-007 SHALL have port ld_data, input, 8 bits: Q0.7 operand.
REQ-008 SHALL have port start, input, 1 bit: run request, sampled in IDLE only.
REQ-009 SHALL have port busy, output, 1 bit: high outside IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at run completion.
REQ-011 SHALL have port tx_data, output, 8 bits: operand byte to the attention engine slave port.
REQ-012 SHALL have port tx_vld, output, 1 bit: operand byte valid.
REQ-013 SHALL have port tx_rdy, input, 1 bit: engine ready.
REQ-014 SHALL have port rx_data, input, 9 bits: UQ3.6 e^x result from the engine master port.
REQ-015 SHALL have port rx_vld, input, 1 bit: result valid.
REQ-016 SHALL have port rx_rdy, output, 1 bit: result ready.
REQ-017 SHALL have port res_sel, input, 2 bits: selects a stored result.
REQ-018 SHALL have port res_out, output, 9 bits: result[res_sel], combinational read.
REQ-019 SHALL have port sum_out, output, 11 bits: sum of the N_KEYS results of the last run.

Function
REQ-020 SHALL write ld_data to the addressed operand register on ld_we in IDLE; ld_we when busy or with out-of-range ld_addr SHALL be ignored.
REQ-021 SHALL use states IDLE, SEND_A, SEND_B, DRAIN; start in IDLE -> SEND_A with key j=0, feature i=0; clear result count and sum.
REQ-022 In SEND_A: tx_data=q[i], tx_vld=1; on tx_vld&tx_rdy -> SEND_B.
REQ-023 In SEND_B: tx_data=k[j][i], tx_vld=1; on tx_vld&tx_rdy advance i (then j on i wrap) -> SEND_A, or -> DRAIN after the last pair.
REQ-024 Once tx_vld is high, tx_vld and tx_data SHALL stay stable until the handshake; tx_rdy low for multiple cycles between bytes SHALL be tolerated.
REQ-025 tx_vld SHALL be 0 in IDLE and DRAIN; byte order per run is q0,k[0][0],q1,k[0][1],...,q[N_FEAT-1],k[N_KEYS-1][N_FEAT-1].
REQ-026 rx_rdy SHALL be 1 when busy and result count < N_KEYS, including during SEND_A/SEND_B (results overlap streaming).
REQ-027 On rx_vld&rx_rdy: store rx_data at index = count, increment count, sum += zero-extended rx_data (11 bits, no overflow for N_KEYS=4).
REQ-028 DRAIN -> IDLE when count == N_KEYS, asserting done for exactly that transition cycle; the Nth result arriving while still in SEND_B of the last pair SHALL be counted and DRAIN exited on the next cycle.
REQ-029 start while busy SHALL be ignored; rx_vld while idle SHALL not be accepted (rx_rdy=0).

Reset
REQ-030 rst_n low SHALL asynchronously force: state IDLE, tx_vld=0, tx_data=0, rx_rdy=0, done=0, busy=0, i=j=count=0, sum=0, results=0; operand registers SHALL reset to 0.
REQ-031 Reset mid-run SHALL abandon the run with no done pulse; the next start SHALL begin at q0.

Structure
REQ-032 A shared package attn_pkg SHALL hold the feeder state enum, operand width 8, result width 9, sum width 11, and default N_FEAT/N_KEYS.
REQ-033 One sub-module attn_result_acc (result store, count, sum, rx handshake) SHALL be used; sequencing and operand storage stay in attn_feeder.

Verification
REQ-034 Load q={0x40,0x40,0x40,0x40}, k all 0x20, tx_rdy=1 always -> 32 bytes alternating 0x40,0x20, one per cycle, tx_vld continuous.
REQ-035 tx_rdy pattern 1,0,1 per pair (engine FIRST/WAIT4SECOND/READY) -> tx_data held at k[j][i] across the low cycle, no byte skipped or repeated.
REQ-036 rx results 0x040,0x080,0x100,0x1FF -> res_out per index equals them, sum_out=0x3BF, single done pulse after 4th acceptance.
REQ-037 Assert rst_n low after 5 bytes sent -> tx_vld=0 immediately, no done; restart streams from q0.
REQ-038 start pulsed while busy and ld_we while busy -> no effect on byte stream or operands.
REQ-039 rx_vld high while idle -> rx_rdy=0, count and sum unchanged.
